// File: rtl/sysop_issue_if.sv
// Execute-stage to system-op issue handshake: one instruction plus its fault
// flags per transfer, accepted when in_valid and in_ready are both high.
interface sysop_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_inst;
   logic [2:0]  in_kind;
   logic [11:0] in_csr_addr;
   logic [63:0] in_wdata;
   logic        in_fetch_pf;
   logic        in_illegal;
   logic        in_mem_fault;
   logic        in_mem_store;
   logic [63:0] in_badaddr;

   modport master (
      output in_valid, in_pc, in_inst, in_kind, in_csr_addr, in_wdata,
             in_fetch_pf, in_illegal, in_mem_fault, in_mem_store, in_badaddr,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_pc, in_inst, in_kind, in_csr_addr, in_wdata,
             in_fetch_pf, in_illegal, in_mem_fault, in_mem_store, in_badaddr,
      output in_ready
   );
endinterface

// File: rtl/sysop_issue.sv
// System-op issue: turns an accepted instruction into one csr op cycle, then
// redirects fetch and holds flush for FLUSH_CYCLES when csr takes a trap.
module sysop_issue #(
   parameter int FLUSH_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   sysop_issue_if.slave      ex,
   input  logic [1:0]        priv,
   output logic [4:0]        op,
   output logic [63:0]       pc,
   output logic [63:0]       tval,
   output logic [63:0]       wdata,
   input  logic              trap_en,
   input  logic [63:0]       trap_pc,
   output logic              flush,
   output logic              redirect_valid,
   output logic [63:0]       redirect_pc
);

   localparam logic [4:0] SYSOP_NONE  = 5'h00;
   localparam logic [4:0] SYSOP_CSR_W = 5'h01;
   localparam logic [4:0] SYSOP_CSR_S = 5'h02;
   localparam logic [4:0] SYSOP_CSR_C = 5'h03;
   localparam logic [4:0] SYSOP_RET   = 5'h04;

   localparam logic [2:0] KIND_CSRRW  = 3'd1;
   localparam logic [2:0] KIND_CSRRS  = 3'd2;
   localparam logic [2:0] KIND_CSRRC  = 3'd3;
   localparam logic [2:0] KIND_XRET   = 3'd4;
   localparam logic [2:0] KIND_ECALL  = 3'd5;
   localparam logic [2:0] KIND_EBREAK = 3'd6;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  op_q, op_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] tval_q, tval_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] redirect_pc_q, redirect_pc_d;
   logic        redirect_valid_q, redirect_valid_d;

   logic        dec_issue;
   logic [4:0]  dec_op;
   logic [63:0] dec_tval;
   logic [63:0] dec_wdata;

   // Fixed-priority decode: faults first, then ECALL/EBREAK, then CSR/xRET.
   always_comb begin
      dec_issue = 1'b1;
      dec_op    = SYSOP_NONE;
      dec_tval  = 64'd0;
      dec_wdata = 64'd0;
      if (ex.in_fetch_pf) begin
         dec_op   = {1'b1, 4'd12};
         dec_tval = ex.in_pc;
      end else if (ex.in_illegal) begin
         dec_op   = {1'b1, 4'd2};
         dec_tval = {32'd0, ex.in_inst};
      end else if (ex.in_kind == KIND_ECALL) begin
         // Causes 8/9/11 for U/S/M are 8 + priv.
         dec_op = {1'b1, 2'b10, priv};
      end else if (ex.in_kind == KIND_EBREAK) begin
         dec_op   = {1'b1, 4'd3};
         dec_tval = ex.in_pc;
      end else if (ex.in_mem_fault) begin
         dec_op   = ex.in_mem_store ? {1'b1, 4'd15} : {1'b1, 4'd13};
         dec_tval = ex.in_badaddr;
      end else begin
         case (ex.in_kind)
            KIND_CSRRW: begin
               dec_op    = SYSOP_CSR_W;
               dec_tval  = {52'd0, ex.in_csr_addr};
               dec_wdata = ex.in_wdata;
            end
            KIND_CSRRS: begin
               dec_op    = SYSOP_CSR_S;
               dec_tval  = {52'd0, ex.in_csr_addr};
               dec_wdata = ex.in_wdata;
            end
            KIND_CSRRC: begin
               dec_op    = SYSOP_CSR_C;
               dec_tval  = {52'd0, ex.in_csr_addr};
               dec_wdata = ex.in_wdata;
            end
            KIND_XRET: dec_op = SYSOP_RET;
            default:   dec_issue = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      op_d             = SYSOP_NONE;
      pc_d             = 64'd0;
      tval_d           = 64'd0;
      wdata_d          = 64'd0;
      redirect_pc_d    = redirect_pc_q;
      redirect_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex.in_valid && dec_issue) begin
               state_d = S_ISSUE;
               op_d    = dec_op;
               pc_d    = ex.in_pc;
               tval_d  = dec_tval;
               wdata_d = dec_wdata;
            end
         end
         S_ISSUE: begin
            if (trap_en) begin
               state_d          = S_FLUSH;
               redirect_pc_d    = trap_pc;
               redirect_valid_d = 1'b1;
               cnt_d            = FLUSH_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         cnt_q            <= 4'd0;
         op_q             <= SYSOP_NONE;
         pc_q             <= 64'd0;
         tval_q           <= 64'd0;
         wdata_q          <= 64'd0;
         redirect_pc_q    <= 64'd0;
         redirect_valid_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         op_q             <= op_d;
         pc_q             <= pc_d;
         tval_q           <= tval_d;
         wdata_q          <= wdata_d;
         redirect_pc_q    <= redirect_pc_d;
         redirect_valid_q <= redirect_valid_d;
      end
   end

   assign ex.in_ready      = (state_q == S_IDLE);
   assign flush            = (state_q == S_FLUSH);
   assign op               = op_q;
   assign pc               = pc_q;
   assign tval             = tval_q;
   assign wdata            = wdata_q;
   assign redirect_pc      = redirect_pc_q;
   assign redirect_valid   = redirect_valid_q;

endmodule

// File: doc/sysop_issue.md
SYSOP_ISSUE -- requirements
Module: sysop_issue

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3, SHALL set the number of cycles flush is held after a taken trap; legal range 1..15.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 in_valid / in_ready  in / out  1 / 1  SHALL form the handshake from the execute stage; a transfer occurs when both are high at a clock edge.
REQ-005 in_pc  in  64, in_inst  in  32, in_kind  in  3, in_csr_addr  in  12, in_wdata  in  64  SHALL carry the instruction, its PC, its system-op kind, its CSR address and its CSR write data.
REQ-006 in_kind encoding: 0 none, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 xRET, 5 ECALL, 6 EBREAK, 7 reserved (treated as none).
REQ-007 in_fetch_pf, in_illegal, in_mem_fault, in_mem_store  in  1 each; in_badaddr  in  64  SHALL carry fault flags, load/store select and the faulting address.
REQ-008 priv  in  2  SHALL be the current privilege from csr (U=0, S=1, M=3).
REQ-009 op  out  5, pc  out  64, tval  out  64, wdata  out  64  SHALL drive csr; all are registered.
REQ-010 trap_en  in  1, trap_pc  in  64  SHALL be csr's combinational trap response.
REQ-011 flush  out  1, redirect_valid  out  1, redirect_pc  out  64  SHALL drive pipeline squash and fetch redirect.

Function
REQ-012 The FSM SHALL have three states: IDLE, ISSUE, FLUSH. in_ready SHALL be 1 only in IDLE.
REQ-013 On a transfer, the op SHALL be selected by fixed priority: in_fetch_pf (cause 12) > in_illegal (cause 2) > ECALL (cause 8 for U, 9 for S, 11 for M) > EBREAK (cause 3) > in_mem_fault (cause 13 load, 15 store) > CSRRW/CSRRS/CSRRC/xRET.
REQ-014 Exception ops SHALL be encoded {1'b1, cause[3:0]}. CSR and xRET ops SHALL use the SYSOP_CSR_W/S/C and SYSOP_RET codes from csr.vh. The idle op SHALL be 5'h00 (no operation).
REQ-015 tval SHALL be: in_pc for fetch page fault and EBREAK; {32'b0, in_inst} for illegal; in_badaddr for memory fault; {52'b0, in_csr_addr} for CSR ops; 0 for ECALL and xRET.
REQ-016 pc SHALL be in_pc. wdata SHALL be in_wdata for CSR ops and 0 otherwise.
REQ-017 A transfer with no fault and kind none or reserved SHALL be consumed without issue; the FSM SHALL stay in IDLE and op SHALL stay 0.
REQ-018 On any other transfer, the FSM SHALL go IDLE->ISSUE, and op/pc/tval/wdata SHALL be valid for exactly the one ISSUE cycle.
REQ-019 In ISSUE the block SHALL sample trap_en.
- If trap_en=1: capture trap_pc into redirect_pc, pulse redirect_valid for one cycle (the first FLUSH cycle), load the counter with FLUSH_CYCLES-1, and go to FLUSH.
- If trap_en=0: return to IDLE.
REQ-020 On leaving ISSUE, op SHALL return to 0, and pc/tval/wdata SHALL return to 0.
REQ-021 flush SHALL equal (state==FLUSH). The FLUSH state SHALL last exactly FLUSH_CYCLES cycles, decrementing the counter each cycle, then go to IDLE.
REQ-022 redirect_pc SHALL hold its value until the next capture.
REQ-023 Issue-to-issue spacing SHALL be at least 2 cycles without a trap, or 2+FLUSH_CYCLES cycles with a trap.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL:
- set the state to IDLE and the counter to 0;
- set op, pc, tval, wdata, redirect_pc to 0;
- set flush and redirect_valid to 0.
in_ready SHALL read 1 from the first cycle after reset release.
REQ-025 A reset asserted during ISSUE or FLUSH SHALL abort the operation with no redirect_valid pulse.

Verification
REQ-026 CSRRS, addr 0x300, wdata 0x8, trap_en=0 -> op=SYSOP_CSR_S, tval=0x300, wdata=0x8 for 1 cycle; in_ready low 1 cycle; flush never asserts.
REQ-027 ECALL at pc 0x8000_0010, priv=0, trap_en=1, trap_pc=0x8000_0100 -> op=5'h18, tval=0; redirect_valid 1 cycle with redirect_pc=0x8000_0100; flush high 3 cycles; in_ready returns high after 5 cycles total.
REQ-028 in_fetch_pf, in_illegal and in_mem_fault all set with kind EBREAK -> op=5'h1C, tval=in_pc.
REQ-029 Store fault at badaddr 0xDEAD_BEE8 -> op=5'h1F, tval=0xDEAD_BEE8; load fault at the same address -> op=5'h1D.
REQ-030 Transfers with kind=0 and kind=7 and no faults -> op stays 0 and in_ready stays 1 on back-to-back transfers.
REQ-031 rst_n=0 in the second FLUSH cycle -> next cycle flush=0, redirect_valid=0, op=0, in_ready=1.
